// File: rtl/free_list.sv
`default_nettype none
// ============================================================================
// Module   : free_list
// Brief    : Circular FIFO of free physical register indices for rename.
//            Supplies the next free register at the head, accepts freed
//            registers from commit at the tail, and snapshots the head per
//            branch tag so recovery/flush returns speculative allocations in
//            a single cycle.
// Revision : 1.0 - initial release
// ============================================================================
module free_list #(
  parameter int NUM_REGS  = 64,
  parameter int NUM_BRATS = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          dequeue,
  output logic [$clog2(NUM_REGS)-1:0]   phys_reg_out,
  input  logic                          enqueue,
  input  logic [$clog2(NUM_REGS)-1:0]   phys_reg_in,
  input  logic                          flush,
  input  logic                          checkpoint,
  input  logic [$clog2(NUM_BRATS)-1:0]  checkpoint_index,
  input  logic                          branch_recovery,
  input  logic [$clog2(NUM_BRATS)-1:0]  branch_resolved_index,
  output logic                          empty,
  output logic                          full,
  output logic [$clog2(NUM_REGS-32):0]  free_count
);

  // The 32 architectural registers are mapped at reset; the rest are free.
  localparam int DEPTH = NUM_REGS - 32;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int REG_W = $clog2(NUM_REGS);

  localparam logic [PTR_W:0] c_PTR_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0] c_PTR_ZERO = '0;
  // Tail starts one full lap ahead of head, so the list begins full.
  localparam logic [PTR_W:0] c_TAIL_RST = {1'b1, {PTR_W{1'b0}}};

  // Storage and pointers; MSB of each pointer is the wrap bit.
  logic [REG_W-1:0] r_array [DEPTH];
  logic [PTR_W:0]   r_head;
  logic [PTR_W:0]   r_tail;
  logic [PTR_W:0]   r_ckpt [NUM_BRATS];

  logic             w_deq;
  logic             w_enq;
  logic [PTR_W:0]   w_head_adv;
  logic [PTR_W:0]   w_tail_next;
  logic [PTR_W:0]   w_head_next;
  logic             w_normal;

  // Status outputs depend only on registered state, so rename sees them
  // in the same cycle it needs them.
  assign empty        = (r_head == r_tail);
  assign full         = (r_head[PTR_W-1:0] == r_tail[PTR_W-1:0]) &&
                        (r_head[PTR_W] != r_tail[PTR_W]);
  assign free_count   = r_tail - r_head;
  assign phys_reg_out = r_array[r_head[PTR_W-1:0]];

  // Accepted requests: p0 is hardwired and never re-enters the list.
  assign w_deq    = dequeue && !empty;
  assign w_enq    = enqueue && (phys_reg_in != '0) && !full;
  assign w_normal = !flush && !branch_recovery;

  // Next-pointer selection: flush > recovery > normal dequeue.
  always_comb begin
    w_head_adv  = w_deq ? (r_head + c_PTR_ONE) : r_head;
    w_tail_next = w_enq ? (r_tail + c_PTR_ONE) : r_tail;
    w_head_next = w_head_adv;
    if (flush) begin
      // Every slot between the new tail and the old head still holds a
      // speculatively allocated register, so one lap behind tail is full.
      w_head_next = {~w_tail_next[PTR_W], w_tail_next[PTR_W-1:0]};
    end else if (branch_recovery) begin
      w_head_next = r_ckpt[branch_resolved_index];
    end
  end

  // Head/tail pointer registers; commit enqueue is honored even on
  // flush/recovery because the committing instruction is older.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head <= c_PTR_ZERO;
      r_tail <= c_TAIL_RST;
    end else begin
      r_head <= w_head_next;
      r_tail <= w_tail_next;
    end
  end

  // Register storage: reset reloads the identity mapping 32..NUM_REGS-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_array[i] <= REG_W'(32 + i);
      end
    end else if (w_enq) begin
      r_array[r_tail[PTR_W-1:0]] <= phys_reg_in;
    end
  end

  // Branch checkpoints save the post-dequeue head so the branch's own
  // allocation survives recovery; ignored during flush/recovery.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_BRATS; i++) begin
        r_ckpt[i] <= c_PTR_ZERO;
      end
    end else if (checkpoint && w_normal) begin
      r_ckpt[checkpoint_index] <= w_head_adv;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_free_list.sv
`default_nettype none
// ============================================================================
// Module   : tb_free_list
// Brief    : Directed bench for free_list. Each stimulus cycle pushes the
//            hand-computed post-edge state into a queue; a monitor pops and
//            compares it against the DUT outputs on the following negedge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_free_list;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       dequeue = 1'b0;
  logic [5:0] phys_reg_out;
  logic       enqueue = 1'b0;
  logic [5:0] phys_reg_in = '0;
  logic       flush = 1'b0;
  logic       checkpoint = 1'b0;
  logic [3:0] checkpoint_index = '0;
  logic       branch_recovery = 1'b0;
  logic [3:0] branch_resolved_index = '0;
  logic       empty;
  logic       full;
  logic [5:0] free_count;

  free_list #(.NUM_REGS(64), .NUM_BRATS(16)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .dequeue               (dequeue),
    .phys_reg_out          (phys_reg_out),
    .enqueue               (enqueue),
    .phys_reg_in           (phys_reg_in),
    .flush                 (flush),
    .checkpoint            (checkpoint),
    .checkpoint_index      (checkpoint_index),
    .branch_recovery       (branch_recovery),
    .branch_resolved_index (branch_resolved_index),
    .empty                 (empty),
    .full                  (full),
    .free_count            (free_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    bit    chk;
    int    out;
    int    emp;
    int    ful;
    int    cnt;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   total  = 0;
  int   passed = 0;

  task automatic chk(input string nm, input string fld, input int act, input int req);
    total++;
    if (act == req) passed++;
    else $display("FAIL %s %s actual=%0d required=%0d", nm, fld, act, req);
  endtask

  // Monitor: the state after each stimulus edge is visible at the next negedge.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      if (mon_e.chk) begin
        chk(mon_e.name, "phys_reg_out", int'(phys_reg_out), mon_e.out);
        chk(mon_e.name, "empty",        int'(empty),        mon_e.emp);
        chk(mon_e.name, "full",         int'(full),         mon_e.ful);
        chk(mon_e.name, "free_count",   int'(free_count),   mon_e.cnt);
      end
    end
  end

  // Apply the currently driven inputs for one edge and queue the expected
  // post-edge state; inputs return to idle afterwards.
  task automatic tick(input string nm, input bit c, input int o, input int e,
                      input int f, input int n);
    exp_t x;
    @(posedge clk);
    x.name = nm; x.chk = c; x.out = o; x.emp = e; x.ful = f; x.cnt = n;
    q.push_back(x);
    #1;
    rst = 1'b0; dequeue = 1'b0; enqueue = 1'b0; phys_reg_in = '0;
    flush = 1'b0; checkpoint = 1'b0; checkpoint_index = '0;
    branch_recovery = 1'b0; branch_resolved_index = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick("reset", 1, 32, 0, 1, 32);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit expired");
    $fatal(1);
  end

  initial begin
    // Drain: 32..63 in order, then empty; extra dequeue is ignored.
    do_reset();
    for (int i = 0; i < 32; i++) begin
      dequeue = 1'b1;
      if (i < 31) tick("drain", 1, 33 + i, 0, 0, 31 - i);
      else        tick("drain_last", 1, 32, 1, 0, 0);
    end
    dequeue = 1'b1;
    tick("deq_empty", 1, 32, 1, 0, 0);

    // Simultaneous dequeue+enqueue(5): first enqueue is refused (list full),
    // afterwards the count holds at 31 and the 5s come back after the wrap.
    do_reset();
    for (int k = 1; k <= 40; k++) begin
      dequeue = 1'b1; enqueue = 1'b1; phys_reg_in = 6'd5;
      tick("ring", 1, (k < 32) ? 32 + k : 5, 0, 0, 31);
    end

    // Branch recovery to tag 7, saved alongside the 4th dequeue.
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      dequeue = 1'b1;
      tick("br_deq", 1, 32 + i, 0, 0, 32 - i);
    end
    dequeue = 1'b1; checkpoint = 1'b1; checkpoint_index = 4'd7;
    tick("br_ckpt", 1, 36, 0, 0, 28);
    dequeue = 1'b1; tick("br_deq36", 1, 37, 0, 0, 27);
    dequeue = 1'b1; tick("br_deq37", 1, 38, 0, 0, 26);
    branch_recovery = 1'b1; branch_resolved_index = 4'd7; dequeue = 1'b1;
    tick("br_recover", 1, 36, 0, 0, 28);
    dequeue = 1'b1; tick("br_after", 1, 37, 0, 0, 27);

    // Flush: 10 allocated, p2 committed, flush with commit of p4.
    do_reset();
    for (int j = 1; j <= 10; j++) begin
      dequeue = 1'b1;
      tick("fl_deq", 1, 32 + j, 0, 0, 32 - j);
    end
    enqueue = 1'b1; phys_reg_in = 6'd2;
    tick("fl_commit", 1, 42, 0, 0, 23);
    flush = 1'b1; enqueue = 1'b1; phys_reg_in = 6'd4; dequeue = 1'b1;
    checkpoint = 1'b1; checkpoint_index = 4'd3;
    tick("fl_flush", 1, 34, 0, 1, 32);
    for (int j = 1; j <= 8; j++) begin
      dequeue = 1'b1;
      tick("fl_replay", 1, 34 + j, 0, 0, 32 - j);
    end

    // Ignored enqueues: while full, and of p0.
    do_reset();
    enqueue = 1'b1; phys_reg_in = 6'd13;
    tick("ign_full", 1, 32, 0, 1, 32);
    dequeue = 1'b1; tick("ign_deq", 1, 33, 0, 0, 31);
    enqueue = 1'b1; phys_reg_in = 6'd0;
    tick("ign_p0", 1, 33, 0, 0, 31);
    enqueue = 1'b1; phys_reg_in = 6'd9;
    tick("ign_refill", 1, 33, 0, 1, 32);
    for (int i = 1; i <= 31; i++) begin
      dequeue = 1'b1;
      tick("ign_walk", (i == 31), 9, 0, 0, 1);
    end

    // Priority: flush beats recovery; reset beats everything.
    do_reset();
    dequeue = 1'b1; tick("pr_deq", 1, 33, 0, 0, 31);
    dequeue = 1'b1; tick("pr_deq", 1, 34, 0, 0, 30);
    dequeue = 1'b1; checkpoint = 1'b1; checkpoint_index = 4'd1;
    tick("pr_ckpt", 1, 35, 0, 0, 29);
    flush = 1'b1; branch_recovery = 1'b1; branch_resolved_index = 4'd1;
    tick("pr_flush_br", 1, 32, 0, 1, 32);
    for (int j = 1; j <= 12; j++) begin
      dequeue = 1'b1;
      tick("pr_deq12", 1, 32 + j, 0, 0, 32 - j);
    end
    enqueue = 1'b1; phys_reg_in = 6'd7;
    tick("pr_commit", 1, 44, 0, 0, 21);
    rst = 1'b1; dequeue = 1'b1; enqueue = 1'b1; phys_reg_in = 6'd7; flush = 1'b1;
    tick("pr_rst", 1, 32, 0, 1, 32);
    // Checkpoint tag 7 was written earlier; reset must have cleared it.
    dequeue = 1'b1; tick("pr_post", 1, 33, 0, 0, 31);
    dequeue = 1'b1; tick("pr_post", 1, 34, 0, 0, 30);
    branch_recovery = 1'b1; branch_resolved_index = 4'd7;
    tick("pr_ckpt_clr", 1, 32, 0, 1, 32);

    repeat (2) @(posedge clk);
    chk("end", "queue_left", q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
